// File: rtl/cache_controller.sv
// 2-way set-associative, write-back / write-allocate cache controller holding
// four lines in front of a tagged backing memory.
module cache_controller #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_dataIn,
   output logic [DATA_W-1:0] cpu_dataOut,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic              cpu_error,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut,
   input  logic              mem_hit
);

   localparam int         TAG_W    = ADDR_W - 1;
   localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                miss_q, miss_d;
   logic                victim_q, victim_d;
   logic [3:0]          valid_q, valid_d;
   logic [3:0]          dirty_q, dirty_d;
   logic [1:0]          lru_q, lru_d;
   logic [TAG_W-1:0]    tag_q [4];
   logic [TAG_W-1:0]    tag_d [4];
   logic [DATA_W-1:0]   data_q [4];
   logic [DATA_W-1:0]   data_d [4];
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                ready_q, ready_d;
   logic                hit_q, hit_d;
   logic                err_q, err_d;

   // Lines are addressed as {way, set}.
   logic             idx;
   logic [TAG_W-1:0] tag_req;
   logic [1:0]       line0, line1, hline, vline, vsel_line;
   logic             hit0, hit1, hit_way, victim_sel;

   assign idx        = addr_q[0];
   assign tag_req    = addr_q[ADDR_W-1:1];
   assign line0      = {1'b0, idx};
   assign line1      = {1'b1, idx};
   assign hit0       = valid_q[line0] && (tag_q[line0] == tag_req);
   assign hit1       = valid_q[line1] && (tag_q[line1] == tag_req);
   assign hit_way    = ~hit0;
   assign hline      = {hit_way, idx};
   assign victim_sel = !valid_q[line0] ? 1'b0 : (!valid_q[line1] ? 1'b1 : lru_q[idx]);
   assign vsel_line  = {victim_sel, idx};
   assign vline      = {victim_q, idx};

   always_comb begin
      // NOTE: every next-state value starts from its register so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      miss_d   = miss_q;
      victim_d = victim_q;
      valid_d  = valid_q;
      dirty_d  = dirty_q;
      lru_d    = lru_q;
      tag_d    = tag_q;
      data_d   = data_q;
      dout_d   = dout_q;
      ready_d  = 1'b0;
      hit_d    = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               write_d = cpu_write;
               addr_d  = cpu_address;
               wdata_d = cpu_dataIn;
               miss_d  = 1'b0;
               cnt_d   = 4'd0;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit0 || hit1) begin
               if (write_q) begin
                  data_d[hline]  = wdata_q;
                  dirty_d[hline] = 1'b1;
                  dout_d         = wdata_q;
               end else begin
                  dout_d = data_q[hline];
               end
               lru_d[idx] = ~hit_way;
               ready_d    = 1'b1;
               hit_d      = ~miss_q;
               state_d    = IDLE;
            end else begin
               miss_d   = 1'b1;
               victim_d = victim_sel;
               cnt_d    = 4'd0;
               state_d  = (valid_q[vsel_line] && dirty_q[vsel_line]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (cnt_q == LAT_LAST) begin
               dirty_d[vline] = 1'b0;
               cnt_d          = 4'd0;
               state_d        = ALLOCATE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ALLOCATE: begin
            if (cnt_q == LAT_LAST) begin
               cnt_d = 4'd0;
               if (mem_hit) begin
                  valid_d[vline] = 1'b1;
                  dirty_d[vline] = 1'b0;
                  tag_d[vline]   = tag_req;
                  data_d[vline]  = mem_dataOut;
                  state_d        = COMPARE;
               end else begin
                  dout_d  = '0;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         miss_q   <= 1'b0;
         victim_q <= 1'b0;
         valid_q  <= '0;
         dirty_q  <= '0;
         lru_q    <= '0;
         dout_q   <= '0;
         ready_q  <= 1'b0;
         hit_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update together at the edge.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         miss_q   <= miss_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
         dirty_q  <= dirty_d;
         lru_q    <= lru_d;
         dout_q   <= dout_d;
         ready_q  <= ready_d;
         hit_q    <= hit_d;
         err_q    <= err_d;
      end
   end

   // NOTE: tag/data storage is qualified by valid bits, so it needs no reset.
   always_ff @(posedge clock) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign busy        = (state_q != IDLE);
   assign mem_req     = (state_q == WRITEBACK) || (state_q == ALLOCATE);
   assign mem_write   = (state_q == WRITEBACK);
   assign mem_address = (state_q == WRITEBACK) ? {tag_q[vline], idx} :
                        (state_q == ALLOCATE)  ? addr_q : '0;
   assign mem_dataIn  = (state_q == WRITEBACK) ? data_q[vline] : '0;
   assign cpu_dataOut = dout_q;
   assign cpu_ready   = ready_q;
   assign cpu_hit     = hit_q;
   assign cpu_error   = err_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: a transaction-level cache/memory model predicts every
// cycle of each request; a compare process checks the DUT on every clock.
module tb_cache_controller;

   localparam int ML = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_req = 1'b0, cpu_write = 1'b0;
   logic [7:0] cpu_address = 8'h00, cpu_dataIn = 8'h00;
   logic [7:0] cpu_dataOut;
   logic       cpu_ready, cpu_hit, cpu_error, busy;
   logic       mem_req, mem_write;
   logic [7:0] mem_address, mem_dataIn;
   logic [7:0] mem_dataOut = 8'h00;
   logic       mem_hit = 1'b0;

   always #5 clock = ~clock;

   cache_controller #(.MEM_LATENCY(ML), .ADDR_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
      .cpu_dataIn(cpu_dataIn), .cpu_dataOut(cpu_dataOut), .cpu_ready(cpu_ready),
      .cpu_hit(cpu_hit), .cpu_error(cpu_error), .busy(busy),
      .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
      .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .mem_hit(mem_hit)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle view of all DUT outputs.
   typedef struct packed {
      logic       busy;
      logic       mreq;
      logic       mwr;
      logic [7:0] maddr;
      logic [7:0] mdin;
      logic       rdy;
      logic       hit;
      logic       err;
      logic [7:0] dout;
   } cyc_t;

   typedef struct packed {
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
   } txn_t;

   function automatic cyc_t mk(input logic b, input logic mq, input logic mw,
                               input logic [7:0] ma, input logic [7:0] md,
                               input logic r, input logic h, input logic e,
                               input logic [7:0] dout);
      cyc_t c;
      c = '{busy: b, mreq: mq, mwr: mw, maddr: ma, mdin: md, rdy: r, hit: h, err: e, dout: dout};
      return c;
   endfunction

   // Reference state: cache contents per [set][way], backing memory image.
   bit         m_valid [2][2];
   bit         m_dirty [2][2];
   logic [6:0] m_tag   [2][2];
   logic [7:0] m_data  [2][2];
   bit         m_lru   [2];
   logic [7:0] ref_mem [logic [7:0]];
   logic [7:0] bmem    [logic [7:0]];
   logic [7:0] cur_dout = 8'h00;
   cyc_t       exp_q [$];

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_lru[s] = 1'b0;
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
      end
      cur_dout = 8'h00;
   endtask

   task automatic respond(input bit s, input bit w, input bit wr, input logic [7:0] d, input bit first);
      if (wr) begin
         m_data[s][w]  = d;
         m_dirty[s][w] = 1'b1;
         cur_dout      = d;
      end else begin
         cur_dout = m_data[s][w];
      end
      m_lru[s] = ~w;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, first, 1'b0, cur_dout));
   endtask

   task automatic model_request(input bit wr, input logic [7:0] a, input logic [7:0] d);
      bit         s, v;
      logic [6:0] t;
      logic [7:0] wa;
      int         hw;
      s  = a[0];
      t  = a[7:1];
      hw = -1;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, cur_dout));
      for (int w = 0; w < 2; w++)
         if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
      if (hw >= 0) begin
         respond(s, hw[0], wr, d, 1'b1);
      end else begin
         if (!m_valid[s][0])      v = 1'b0;
         else if (!m_valid[s][1]) v = 1'b1;
         else                     v = m_lru[s];
         if (m_valid[s][v] && m_dirty[s][v]) begin
            wa = {m_tag[s][v], s};
            repeat (ML) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, wa, m_data[s][v], 1'b0, 1'b0, 1'b0, cur_dout));
            ref_mem[wa]   = m_data[s][v];
            m_dirty[s][v] = 1'b0;
         end
         repeat (ML) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0, cur_dout));
         if (ref_mem.exists(a)) begin
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = t;
            m_data[s][v]  = ref_mem[a];
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, cur_dout));
            respond(s, v, wr, d, 1'b0);
         end else begin
            cur_dout = 8'h00;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00));
         end
      end
   endtask

   // Backing memory responder; returns noise whenever no read is in progress.
   always @(negedge clock) begin
      if (mem_req && !mem_write) begin
         mem_hit     = bmem.exists(mem_address);
         mem_dataOut = mem_hit ? bmem[mem_address] : 8'($urandom);
      end else begin
         mem_hit     = 1'($urandom);
         mem_dataOut = 8'($urandom);
      end
      if (mem_req && mem_write) bmem[mem_address] = mem_dataIn;
   end

   // Compare process plus observation of responses and memory transactions.
   int         edge_no = 0;
   int         obs_rdy = 0;
   int         obs_lat = 0;
   logic [7:0] obs_dout = 8'h00;
   logic       obs_hit = 1'b0, obs_err = 1'b0;
   txn_t       obs_mem [$];
   logic       prev_req = 1'b0, prev_wr = 1'b0;

   always @(posedge clock) begin
      cyc_t exp_c, act_c;
      #1;
      if (exp_q.size() > 0) begin
         exp_c = exp_q.pop_front();
         edge_no++;
      end else begin
         exp_c = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, cur_dout);
      end
      act_c = {busy, mem_req, mem_write, mem_address, mem_dataIn, cpu_ready, cpu_hit, cpu_error, cpu_dataOut};
      check("cycle", 32'(act_c), 32'(exp_c));
      if (cpu_ready) begin
         obs_rdy++;
         obs_lat  = edge_no;
         obs_dout = cpu_dataOut;
         obs_hit  = cpu_hit;
         obs_err  = cpu_error;
      end
      if (mem_req && (!prev_req || prev_wr != mem_write))
         obs_mem.push_back('{wr: mem_write, a: mem_address, d: mem_dataIn});
      prev_req = mem_req;
      prev_wr  = mem_write;
   end

   task automatic start_req(input bit wr, input logic [7:0] a, input logic [7:0] d);
      @(negedge clock);
      cpu_req     = 1'b1;
      cpu_write   = wr;
      cpu_address = a;
      cpu_dataIn  = d;
      edge_no     = 0;
      obs_rdy     = 0;
      obs_lat     = 0;
      obs_mem.delete();
      model_request(wr, a, d);
   endtask

   // Issues one request and pulses junk requests while the controller is busy.
   task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d);
      int len;
      start_req(wr, a, d);
      len = exp_q.size();
      @(negedge clock);
      for (int k = 0; k < len - 1; k++) begin
         cpu_req     = 1'($urandom);
         cpu_write   = 1'($urandom);
         cpu_address = 8'($urandom);
         cpu_dataIn  = 8'($urandom);
         @(negedge clock);
      end
      cpu_req = 1'b0;
      check("one_ready", obs_rdy, 1);
   endtask

   task automatic check_resp(input string tag, input logic [7:0] dout, input bit hit,
                             input bit err, input int lat, input int n_mem);
      check({tag, "_dout"}, obs_dout, dout);
      check({tag, "_hit"}, obs_hit, hit);
      check({tag, "_err"}, obs_err, err);
      check({tag, "_lat"}, obs_lat, lat);
      check({tag, "_memtxn"}, obs_mem.size(), n_mem);
   endtask

   logic [7:0] pool [13] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h64, 8'h65, 8'h66,
                             8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'hA5};

   initial begin
      int ja;
      bmem[8'h00] = 8'h05; bmem[8'h65] = 8'h03; bmem[8'h66] = 8'h01;
      bmem[8'h67] = 8'h00; bmem[8'h69] = 8'h2C; bmem[8'h01] = 8'hF1;
      bmem[8'h68] = 8'h68; bmem[8'h6A] = 8'h5A; bmem[8'h6B] = 8'h6B;
      ref_mem = bmem;
      model_reset();

      repeat (3) @(negedge clock);
      check("reset_outputs", {cpu_dataOut, cpu_ready, cpu_hit, cpu_error, busy,
                              mem_req, mem_write, mem_address, mem_dataIn}, 32'h0);
      reset = 1'b0;

      // Cold read: one refill read at 0x65.
      do_req(1'b0, 8'h65, 8'h00);
      check_resp("cold", 8'h03, 1'b0, 1'b0, 5, 1);
      if (obs_mem.size() > 0) check("cold_txn", 32'(obs_mem[0]), 32'({1'b0, 8'h65, 8'h00}));

      do_req(1'b0, 8'h65, 8'h00);
      check_resp("rehit", 8'h03, 1'b1, 1'b0, 2, 0);

      do_req(1'b1, 8'h65, 8'hAA);
      check_resp("wrhit", 8'hAA, 1'b1, 1'b0, 2, 0);

      do_req(1'b0, 8'h67, 8'h00);
      check_resp("fill67", 8'h00, 1'b0, 1'b0, 5, 1);

      // Dirty LRU victim 0x65 is written back before 0x69 is refilled.
      do_req(1'b0, 8'h69, 8'h00);
      check_resp("evict", 8'h2C, 1'b0, 1'b0, 7, 2);
      if (obs_mem.size() > 1) begin
         check("evict_wb", 32'(obs_mem[0]), 32'({1'b1, 8'h65, 8'hAA}));
         check("evict_rd", 32'(obs_mem[1]), 32'({1'b0, 8'h69, 8'h00}));
      end

      do_req(1'b0, 8'h10, 8'h00);
      check_resp("absent", 8'h00, 1'b0, 1'b1, 4, 1);
      do_req(1'b0, 8'h10, 8'h00);
      check_resp("absent2", 8'h00, 1'b0, 1'b1, 4, 1);

      do_req(1'b1, 8'h66, 8'h7E);
      check_resp("wrmiss", 8'h7E, 1'b0, 1'b0, 5, 1);
      if (obs_mem.size() > 0) check("wrmiss_txn", 32'(obs_mem[0]), 32'({1'b0, 8'h66, 8'h00}));
      do_req(1'b0, 8'h66, 8'h00);
      check_resp("rd66", 8'h7E, 1'b1, 1'b0, 2, 0);
      check("mem66_unwritten", bmem[8'h66], 8'h01);

      // Reset while the refill of 0x00 is in flight.
      start_req(1'b0, 8'h00, 8'h00);
      ja = 0;
      while (ja < exp_q.size() && !(exp_q[ja].mreq && !exp_q[ja].mwr)) ja++;
      @(negedge clock);
      cpu_req = 1'b0;
      repeat (ja) @(negedge clock);
      check("alloc_active", {mem_req, mem_write, mem_address}, {1'b1, 1'b0, 8'h00});
      reset = 1'b1;
      #1;
      exp_q.delete();
      model_reset();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_all_out", {cpu_dataOut, cpu_ready, cpu_hit, cpu_error, busy,
                            mem_req, mem_write, mem_address, mem_dataIn}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Cache was invalidated; 0x65 now holds the written-back value.
      do_req(1'b0, 8'h65, 8'h00);
      check_resp("postrst", 8'hAA, 1'b0, 1'b0, 5, 1);

      repeat (300) do_req(1'($urandom), pool[$urandom_range(0, 12)], 8'($urandom));

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-back, write-allocate cache controller.
- Sits between the CPU-side requester and the tagged backing memory (8-bit address, 8-bit data, hit flag).
- Services CPU reads and writes from 4 internal lines. On a miss it writes back a dirty victim, refills from backing memory, then completes the request.
- Reports hit/miss per request, and an error when the backing memory does not contain the address.

Parameters:
MEM_LATENCY, 2, cycles the controller holds a memory request before sampling mem_dataOut/mem_hit (range 1..15)
ADDR_W, 8, address width
DATA_W, 8, data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  request strobe, sampled only when busy=0
cpu_write  input  1  1=write, 0=read
cpu_address  input  8  request address
cpu_dataIn  input  8  write data
cpu_dataOut  output  8  read data, registered, held until next response
cpu_ready  output  1  one-cycle response pulse
cpu_hit  output  1  valid with cpu_ready; 1=hit on first lookup
cpu_error  output  1  valid with cpu_ready; 1=address absent in backing memory
busy  output  1  high in any state other than IDLE
mem_req  output  1  memory access active
mem_write  output  1  1=write-back, 0=refill read
mem_address  output  8  memory address
mem_dataIn  output  8  data to memory (write-back)
mem_dataOut  input  8  data from memory
mem_hit  input  1  memory found the address

Behaviour:
- Organisation:
  - index = address[0]; tag = address[7:1].
  - Per line: valid, dirty, tag[6:0], data[7:0].
  - One LRU bit per set, naming the least-recently-used way.
- Reset (async, immediate):
  - State to IDLE.
  - All valid, dirty and LRU bits cleared.
  - All outputs 0.
  - Reset mid-operation aborts the operation; dirty data is lost, and mem_req drops immediately.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - On cpu_req=1, latch cpu_write, cpu_address and cpu_dataIn; set miss_flag=0; go to COMPARE.
  - cpu_req while busy=1 is ignored (not queued).
- COMPARE, hit in way w:
  - Read: cpu_dataOut <= data[w].
  - Write: data[w] <= latched dataIn, dirty[w] <= 1, and cpu_dataOut <= latched dataIn.
  - LRU <= ~w.
  - cpu_ready=1 and cpu_hit=~miss_flag for one cycle; go to IDLE.
  - Hit latency: cpu_ready is high exactly 2 cycles after the edge that sampled cpu_req.
- COMPARE, miss:
  - Set miss_flag=1.
  - Victim = first invalid way (way0 before way1); if both ways are valid, victim = LRU way.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK:
  - Drive mem_req=1, mem_write=1, mem_address={victim tag, index}, mem_dataIn=victim data.
  - A 4-bit counter runs for MEM_LATENCY cycles, then dirty[victim] <= 0 and go to ALLOCATE.
  - mem_hit is ignored in this state.
- ALLOCATE:
  - Drive mem_req=1, mem_write=0, mem_address=latched address; count MEM_LATENCY cycles, then sample.
  - mem_hit=1: install valid=1, dirty=0, tag, data=mem_dataOut; go to COMPARE, which then hits and completes with cpu_hit=0.
  - mem_hit=0: no install; cpu_dataOut <= 0; cpu_ready=1, cpu_error=1, cpu_hit=0; go to IDLE.
  - The victim way was already written back and stays valid and clean.
- Output timing and stability:
  - mem_* outputs are 0 outside WRITEBACK and ALLOCATE.
  - mem_address and mem_dataIn are stable for the whole access.
  - cpu_error is 0 on every non-error response.
- Full miss latency: 2 + MEM_LATENCY + 1 (+MEM_LATENCY if write-back) cycles from the sampling edge.
- The counter resets to 0 on each state entry.

Test Plan:
- Bench memory model holds 0x00→05, 0x65→03, 0x66→01, 0x67→00, 0x69→2C; MEM_LATENCY=2.
- Cold read 0x65 -> one mem read at 0x65; response cpu_dataOut=03, cpu_hit=0, cpu_ready 5 cycles after request. Repeat read 0x65 -> cpu_hit=1 after 2 cycles, no mem_req.
- Write 0x65←AA (hit) -> cpu_hit=1, no mem traffic. Then read 0x67 (miss, fills way1), then read 0x69 -> WRITEBACK mem_write=1, addr 0x65, data AA, then refill 0x69; cpu_dataOut=2C, cpu_hit=0.
- Read 0x10 (absent, mem_hit=0) -> cpu_error=1, cpu_hit=0, cpu_dataOut=00. Re-read 0x10 -> misses again (not installed).
- Write miss 0x66←7E -> refill read 0x66, then write; cpu_hit=0. Read 0x66 -> 7E, hit=1; mem never written during this sequence.
- Assert reset during ALLOCATE of 0x00 -> mem_req=0 and busy=0 immediately, all outputs 0. Next read 0x65 misses (cache invalidated).
- cpu_req pulsed while busy=1 -> ignored: exactly one cpu_ready per accepted request.
